// File: rtl/isqrt_reconstruct.sv
// ---------------------------------------------------------------------------
// isqrt_reconstruct
//
// Rebuilds the radicand N = R*R + M from a square-root result (root R and
// remainder M) so that the output of the digit-by-digit square-root engine
// can be checked against its original operand. R*R is formed by an 8-step
// shift-add multiplier, then M is added in one extra step. The err flag is
// raised when M > 2R (no valid square root leaves such a remainder) or when
// the final sum overflows 16 bits.
//
// Ports:
//   clk      in   1   rising-edge clock
//   rst_n    in   1   asynchronous active-low reset
//   start    in   1   request, sampled only while idle
//   root_in  in   8   root R, captured when start is accepted
//   rem_in   in   9   remainder M, captured when start is accepted
//   busy     out  1   high whenever an operation is in progress
//   done     out  1   one-cycle pulse, result/err valid in that cycle
//   result   out 16   N = R*R + M modulo 2^16, held until the next start
//   err      out  1   invalid remainder or sum carry-out, held with result
// ---------------------------------------------------------------------------
module isqrt_reconstruct (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [7:0]  root_in,
   input  logic [8:0]  rem_in,
   output logic        busy,
   output logic        done,
   output logic [15:0] result,
   output logic        err
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      ADD  = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t      state_q,  state_d;
   logic [7:0]  r_q,      r_d;
   logic [8:0]  m_q,      m_d;
   logic [15:0] acc_q,    acc_d;
   logic [2:0]  cnt_q,    cnt_d;
   logic        inv_q,    inv_d;
   logic [15:0] result_q, result_d;
   logic        err_q,    err_d;
   logic        done_q,   done_d;
   logic        busy_q,   busy_d;

   logic [15:0] partial;
   logic [16:0] sum;

   // Next-state and datapath logic. The multiplier walks the root bits from
   // LSB to MSB, adding the root shifted by the bit position whenever that
   // bit is set; 255*255 fits in 16 bits so the accumulator never overflows.
   // The invalid-remainder test is done once at acceptance and folded into
   // err together with the carry of the final addition. busy and done are
   // computed from the next state so both leave the block as plain flops.
   always_comb begin
      state_d  = state_q;
      r_d      = r_q;
      m_d      = m_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      inv_d    = inv_q;
      result_d = result_q;
      err_d    = err_q;
      partial  = {8'd0, r_q} << cnt_q;
      sum      = {1'b0, acc_q} + {8'd0, m_q};

      case (state_q)
         IDLE: begin
            if (start) begin
               r_d     = root_in;
               m_d     = rem_in;
               acc_d   = 16'd0;
               cnt_d   = 3'd0;
               inv_d   = (rem_in > {root_in, 1'b0});
               state_d = MUL;
            end
         end
         MUL: begin
            if (r_q[cnt_q]) begin
               acc_d = acc_q + partial;
            end
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
               state_d = ADD;
            end
         end
         ADD: begin
            result_d = sum[15:0];
            err_d    = inv_q | sum[16];
            state_d  = DONE;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d != IDLE);
      done_d = (state_d == DONE);
   end

   // All state lives in this one register bank; reset clears everything,
   // which also abandons any operation that was in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         r_q      <= 8'd0;
         m_q      <= 9'd0;
         acc_q    <= 16'd0;
         cnt_q    <= 3'd0;
         inv_q    <= 1'b0;
         result_q <= 16'd0;
         err_q    <= 1'b0;
         done_q   <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         r_q      <= r_d;
         m_q      <= m_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         inv_q    <= inv_d;
         result_q <= result_d;
         err_q    <= err_d;
         done_q   <= done_d;
         busy_q   <= busy_d;
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign result = result_q;
   assign err    = err_q;

endmodule
